// File: rtl/mux_arb_pkg.sv
// Shared constants and FSM state encoding for the 4-channel round-robin mux arbiter.
package mux_arb_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick_4.sv
// Rotating priority encoder: first eligible channel in order ptr+1, ptr+2, ptr+3, ptr.
module rr_pick_4
  import mux_arb_pkg::*;
(
  input  logic [NUM_CH-1:0] eligible,
  input  logic [SEL_W-1:0]  ptr,
  output logic              found,
  output logic [SEL_W-1:0]  winner
);

  always_comb begin
    logic [SEL_W-1:0] idx;
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    // k = 4 wraps to offset 0, so the last holder is searched last.
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = ptr + SEL_W'(k);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter_4ch.sv
// Round-robin arbiter granting bounded bursts on a shared 4:1 single-bit mux;
// the held grant steers the chosen channel's data bit onto y_out.
module mux_rr_arbiter_4ch
  import mux_arb_pkg::*;
#(
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [NUM_CH-1:0] req_in,
  input  logic [NUM_CH-1:0] mask_in,
  input  logic [NUM_CH-1:0] d_in,
  output logic [NUM_CH-1:0] grant_out,
  output logic [SEL_W-1:0]  sel_out,
  output logic              busy_out,
  output logic              y_out,
  output logic              valid_out
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic              busy_q, busy_d;

  logic [NUM_CH-1:0] eligible;
  logic              found;
  logic [SEL_W-1:0]  winner;

  // Valid/ready contract: there is no back-pressure; a data bit is transferred
  // on every cycle where valid_out is high, and the consumer must take it.
  assign eligible = req_in & mask_in;

  rr_pick_4 u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .found    (found),
    .winner   (winner)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_BUSY;
          grant_d = NUM_CH'(1) << winner;
          sel_d   = winner;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Dropped request and burst end collapse into a single release.
        if (!req_in[sel_q] || (cnt_q == LAST_CNT)) begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = sel_q;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= SEL_W'(NUM_CH - 1);
      sel_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  assign grant_out = grant_q;
  assign sel_out   = sel_q;
  assign busy_out  = busy_q;
  assign valid_out = busy_q & req_in[sel_q];
  assign y_out     = valid_out & d_in[sel_q];

endmodule

// File: tb/tb_mux_rr_arbiter_4ch.sv
// Directed bench for mux_rr_arbiter_4ch: two instances (BURST_LEN 8 and 1) checked
// every cycle against a holder/pointer model, plus hand-computed literal checks.
module tb_mux_rr_arbiter_4ch;

  logic       clk;
  logic       rst_in;
  logic [3:0] req_in, mask_in, d_in;

  logic [3:0] grant_a, grant_b;
  logic [1:0] sel_a, sel_b;
  logic       busy_a, busy_b, y_a, y_b, valid_a, valid_b;

  int n_checks = 0;
  int n_fail   = 0;

  mux_rr_arbiter_4ch #(.BURST_LEN(8), .CNT_W(8)) dut (
    .clk_in (clk), .rst_in (rst_in), .req_in (req_in), .mask_in (mask_in), .d_in (d_in),
    .grant_out (grant_a), .sel_out (sel_a), .busy_out (busy_a), .y_out (y_a), .valid_out (valid_a)
  );

  mux_rr_arbiter_4ch #(.BURST_LEN(1), .CNT_W(8)) dut1 (
    .clk_in (clk), .rst_in (rst_in), .req_in (req_in), .mask_in (mask_in), .d_in (d_in),
    .grant_out (grant_b), .sel_out (sel_b), .busy_out (busy_b), .y_out (y_b), .valid_out (valid_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each instance is described by who holds the mux (-1 = nobody), how many
  // busy cycles that holder has had, the last holder (rotation origin) and
  // the last select value.
  int m_hold[2], m_run[2], m_ptr[2], m_sel[2], m_blen[2];
  bit m_live[2];

  initial begin
    m_blen[0] = 8;
    m_blen[1] = 1;
    m_live    = '{0, 0};
  end

  task automatic model_step(input int i);
    if (rst_in) begin
      m_hold[i] = -1; m_run[i] = 0; m_ptr[i] = 3; m_sel[i] = 0; m_live[i] = 1;
    end else if (m_live[i]) begin
      if (m_hold[i] >= 0) begin
        m_run[i]++;
        if (!req_in[m_hold[i]] || m_run[i] == m_blen[i]) begin
          m_ptr[i]  = m_hold[i];
          m_hold[i] = -1;
        end
      end else begin
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (m_ptr[i] + k) % 4;
          if (req_in[c] && mask_in[c]) begin
            m_hold[i] = c; m_sel[i] = c; m_run[i] = 0;
            break;
          end
        end
      end
    end
  endtask

  task automatic model_compare(input int i);
    logic [3:0] g; logic [1:0] s; logic b, v, y;
    logic [3:0] eg; logic eb, ev, ey;
    if (i == 0) begin g = grant_a; s = sel_a; b = busy_a; v = valid_a; y = y_a; end
    else        begin g = grant_b; s = sel_b; b = busy_b; v = valid_b; y = y_b; end
    eb = (m_hold[i] >= 0);
    eg = eb ? (4'b0001 << m_hold[i]) : 4'b0000;
    ev = eb && req_in[m_sel[i]];
    ey = ev && d_in[m_sel[i]];
    chk($sformatf("cyc%0d grant", i), 32'(g), 32'(eg));
    chk($sformatf("cyc%0d sel",   i), 32'(s), 32'(m_sel[i]));
    chk($sformatf("cyc%0d busy",  i), 32'(b), 32'(eb));
    chk($sformatf("cyc%0d valid", i), 32'(v), 32'(ev));
    chk($sformatf("cyc%0d y",     i), 32'(y), 32'(ey));
  endtask

  // Single compare process: advance the model on each edge, then check after it.
  initial begin
    forever begin
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      for (int i = 0; i < 2; i++)
        if (m_live[i]) model_compare(i);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    d_in = 4'($urandom_range(0, 15));
  endtask

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    step();
    rst_in = 1'b1; req_in = 4'b0000; mask_in = 4'b1111;
    sample();
    step();
    rst_in = 1'b0;
  endtask

  // Counts busy samples of the BURST_LEN=8 instance; returns on the first idle sample.
  task automatic count_burst(output int n);
    n = 0;
    while (busy_a && n < 300) begin
      n++;
      step();
      sample();
    end
  endtask

  // ---------------- directed tests ----------------
  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];
  int n;
  int busy_cnt;
  bit prev_busy;

  initial begin
    rst_in = 1'b1; req_in = '0; mask_in = '0; d_in = '0;

    // Test 1: single requester, full burst, one idle cycle, then re-grant.
    do_reset();
    chk("rst grant", 32'(grant_a), 32'h0);
    chk("rst sel",   32'(sel_a),   32'h0);
    chk("rst busy",  32'(busy_a),  32'h0);
    chk("rst valid", 32'(valid_a), 32'h0);
    chk("rst y",     32'(y_a),     32'h0);
    req_in = 4'b0001;
    sample();
    chk("t1 grant", 32'(grant_a), 32'h1);
    chk("t1 sel",   32'(sel_a),   32'h0);
    chk("t1 y",     32'(y_a),     32'(d_in[0]));
    count_burst(n);
    chk("t1 burst length", 32'(n), 32'd8);
    chk("t1 idle gap", 32'(busy_a), 32'h0);
    step(); sample();
    chk("t1 regrant", 32'(grant_a), 32'h1);

    // Test 2: all requesting -> 0,1,2,3,0 with 8 busy + 1 idle per grant.
    do_reset();
    req_in = 4'b1111;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    got_q = {};
    prev_busy = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      sample();
      if (busy_a) busy_cnt++;
      if (busy_a && !prev_busy) got_q.push_back(sel_a);
      prev_busy = busy_a;
      step();
    end
    chk("t2 grant count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk($sformatf("t2 order[%0d]", k), 32'(got_q[k]), 32'(exp_q[k]));
    chk("t2 busy cycles", 32'(busy_cnt), 32'd36);

    // Test 3: channel 2 drops its request in busy cycle 3.
    do_reset();
    req_in = 4'b0100;
    sample();
    chk("t3 sel", 32'(sel_a), 32'd2);
    step(); sample();
    step(); sample();
    step();
    req_in = 4'b1011;
    #1;
    chk("t3 valid on drop", 32'(valid_a), 32'h0);
    chk("t3 busy on drop",  32'(busy_a),  32'h1);
    sample();
    chk("t3 released", 32'(busy_a), 32'h0);
    step(); sample();
    chk("t3 next grant", 32'(grant_a), 32'h8);

    // Test 4: masks limit arbitration only; unmasking later brings ch0 back.
    do_reset();
    req_in = 4'b1111; mask_in = 4'b0101;
    sample();
    chk("t4 first", 32'(sel_a), 32'd0);
    step(); sample();
    step(); sample();
    step();
    mask_in = 4'b0100;
    sample();
    count_burst(n);
    chk("t4 rest of burst", 32'(n), 32'd5);
    step(); sample();
    chk("t4 second", 32'(grant_a), 32'h4);
    step();
    mask_in = 4'b0101;
    sample();
    count_burst(n);
    chk("t4 ch2 burst", 32'(n), 32'd7);
    step(); sample();
    chk("t4 third", 32'(grant_a), 32'h1);

    // Test 5: reset mid-burst of channel 1 restores pointer and outputs.
    do_reset();
    req_in = 4'b0010;
    sample();
    chk("t5 sel", 32'(sel_a), 32'd1);
    for (int c = 0; c < 3; c++) begin step(); sample(); end
    step();
    rst_in = 1'b1;
    sample();
    chk("t5 grant", 32'(grant_a), 32'h0);
    chk("t5 busy",  32'(busy_a),  32'h0);
    chk("t5 sel0",  32'(sel_a),   32'h0);
    step();
    rst_in = 1'b0; req_in = 4'b0011;
    sample();
    chk("t5 ptr grant", 32'(grant_a), 32'h1);

    // Test 6: BURST_LEN = 1 instance alternates busy/idle for a lone requester.
    do_reset();
    req_in = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      sample();
      chk($sformatf("t6 busy[%0d]", c), 32'(busy_b), 32'((c % 2) == 0));
      if (busy_b) begin
        chk($sformatf("t6 valid[%0d]", c), 32'(valid_b), 32'h1);
        chk($sformatf("t6 y[%0d]", c), 32'(y_b), 32'(d_in[2]));
      end
      step();
    end

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter_4ch.md
Name: mux_rr_arbiter_4ch

Overview:
Round-robin arbiter that shares a 4:1 single-bit mux datapath among four requesters. It picks one requesting channel and holds the grant for a bounded burst. While the grant is held, it drives the mux select and steers the granted channel's data bit to a single serial output with a valid qualifier. It sits between the four channel sources and the shared downstream serial consumer.

Parameters:
BURST_LEN, 8, maximum consecutive BUSY cycles per grant; legal range 1..256.
CNT_W, 8, burst counter width; must satisfy 2^CNT_W >= BURST_LEN.

Ports:
clk_in  input  1  system clock, rising edge.
rst_in  input  1  synchronous, active-high reset.
req_in  input  4  per-channel request, level-sensitive; bit i = channel i.
mask_in  input  4  per-channel enable; 0 excludes the channel from arbitration only.
d_in  input  4  per-channel serial data bit.
grant_out  output  4  one-hot grant, registered.
sel_out  output  2  encoded index of the granted channel, registered; drives the shared mux select.
busy_out  output  1  high while a grant is held, registered.
y_out  output  1  muxed data bit: d_in[sel_out] when valid_out = 1, else 0.
valid_out  output  1  busy_out AND req_in[sel_out], combinational.

Behaviour:
- Interface: one clock (clk_in). Reset (rst_in) is synchronous and active-high.
- Reset values:
  - grant_out = 0, sel_out = 0, busy_out = 0, y_out = 0, valid_out = 0.
  - Priority pointer ptr = 3, so channel 0 has highest priority first.
  - Burst counter cnt = 0. FSM enters IDLE.
- Reset takes effect at the next clk_in edge, including mid-burst. Any in-progress burst is abandoned; there is no partial-release bookkeeping.
- FSM state IDLE:
  - eligible = req_in & mask_in.
  - If eligible != 0: the winner is the first eligible channel in search order ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Next edge on a win: grant_out = onehot(winner), sel_out = winner, busy_out = 1, cnt = 0, go to BUSY.
  - If eligible == 0: stay in IDLE; outputs unchanged at 0.
- FSM state BUSY:
  - Each cycle, cnt increments.
  - Release condition: req_in[sel_out] == 0, OR cnt == BURST_LEN-1.
  - On release, at the next edge: grant_out = 0, busy_out = 0, ptr = sel_out, go to IDLE. sel_out keeps its last value.
  - If both release conditions occur in the same cycle, exactly one release happens.
  - The final burst cycle (cnt == BURST_LEN-1) still delivers data: valid_out = 1 if req_in[sel_out] is high.
- Latency and spacing:
  - Request seen in cycle t gives grant visible in t+1.
  - At least one IDLE cycle always separates consecutive grants, including re-grant to the same channel.
  - A channel held for a full burst gets at most BURST_LEN valid cycles, then loses priority to the other requesters.
- mask_in changes during BUSY do not abort the current grant. Masking affects arbitration only.
- A granted channel that drops req_in produces valid_out = 0 in that cycle and is released at the next edge.
- BURST_LEN = 1: every grant lasts exactly one BUSY cycle. A channel that is continuously requesting alone alternates BUSY/IDLE.
- Fairness: with all four channels requesting continuously, grants rotate 0,1,2,3,0,…
- Invariants: grant_out is one-hot or zero; grant_out == onehot(sel_out) whenever busy_out = 1.

Decomposition:
- Shared package mux_arb_pkg holds:
  - FSM state encoding constants ST_IDLE and ST_BUSY.
  - Channel count NUM_CH = 4 and select width SEL_W = 2.
- One natural sub-module: rr_pick_4, a combinational rotate/priority-encode block.
  - Inputs: eligible[3:0], ptr[1:0].
  - Outputs: found (1 bit), winner[1:0].
- The FSM, counter and output mux stay in the top module.

Test Plan:
1. Reset, then req_in=0001, mask_in=1111 → grant_out=0001 and sel_out=0 one cycle later; valid_out=1 and y_out follows d_in[0] for 8 cycles. After the 8th cycle there is one IDLE cycle, then re-grant to channel 0.
2. req_in=1111 held for 40 cycles, BURST_LEN=8 → grant order 0,1,2,3,0. Each grant is 8 BUSY cycles followed by 1 IDLE cycle.
3. Channel 2 granted; req_in[2] drops at BUSY cycle 3 → valid_out=0 in that cycle and busy_out=0 at the next edge. With req_in=1011 still asserted, the next grant goes to channel 3.
4. req_in=1111, mask_in=0101 → grants alternate between channels 0 and 2 only. Clearing mask_in[0] mid-burst does not end the current channel-0 grant early.
5. rst_in asserted at BUSY cycle 4 of channel 1 → next edge gives grant_out=0, busy_out=0, sel_out=0. With req_in=0011 after reset, the first grant goes to channel 0 (ptr back to 3).
6. BURST_LEN=1, req_in=0100 continuous → busy_out toggles 1,0,1,0… Every BUSY cycle has valid_out=1 and y_out=d_in[2].
